dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of the byte-addressable data memory. It shares the single memory port between the CPU MEM stage and a debug/loader port. Each accepted request is registered, issued to memory for exactly one cycle, and completed with a registered response pulse. It sits between the MEM stage / debug module and the data memory; memory-side outputs connect directly to the memory's read enable, write enable, address, write data and access-control inputs.

Parameters:
ADDR_WIDTH, 17, memory byte-address width; only addr[ADDR_WIDTH-1:0] is meaningful downstream.
FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = CPU always wins ties.

Ports:
clk_i  in  1  clock, single clock domain
rst_ni  in  1  asynchronous active-low reset
cpu_req_i  in  1  CPU request valid
cpu_we_i  in  1  1 = store, 0 = load
cpu_addr_i  in  32  byte address
cpu_wdata_i  in  32  store data
cpu_ctrl_i  in  3  access control: [1:0] size (00 = B, 01 = H, 10 = W), [2] zero-extend
cpu_gnt_o  out  1  request accepted this cycle (req & gnt = handshake)
cpu_rvalid_o  out  1  one-cycle completion pulse for loads and stores
cpu_rdata_o  out  32  load data, valid with rvalid; 0 for stores
cpu_err_o  out  1  access error, valid with rvalid
dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_ctrl_i  in  1/1/32/32/3  debug port; same meanings as the CPU inputs
dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_err_o  out  1/1/32/1  debug port; same meanings as the CPU outputs
mem_read_o  out  1  memory read enable
mem_write_o  out  1  memory write enable
mem_addr_o  out  32  memory address
mem_wdata_o  out  32  memory write data
mem_ctrl_o  out  3  memory access control
mem_rdata_i  in  32  combinational memory read data

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
  - IDLE -> ACCESS when any req is accepted.
  - ACCESS -> RESP unconditionally.
  - RESP -> ACCESS if a new request is accepted this cycle, else RESP -> IDLE.
- Grants:
  - gnt_o is combinational and asserted only in IDLE or RESP, to at most one requester per cycle.
  - On acceptance, the command register captures {we, addr, wdata, ctrl, requester id}.
- Memory drive:
  - In ACCESS, mem_* are driven from the command register: mem_read_o = ~we, mem_write_o = we.
  - In all other states, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o and mem_ctrl_o are 0.
- Timing: accept at edge T; ACCESS during cycle T+1 (store commits at the end of T+1); mem_rdata_i is captured at the end of T+1; rvalid pulses during T+2 on the owning port only.
- Throughput: one access per 2 cycles under continuous requests.
- Response data: rdata_o holds its value until the next response on that port. For stores, rdata_o = 0.
- Arbitration: a last_grant register is updated on every acceptance and resets to DBG, so the CPU wins the first tie.
  - FIXED_PRIO = 0: on a tie, the requester not granted last wins.
  - FIXED_PRIO = 1: the CPU always wins.
  - A single requester is always granted, regardless of priority mode.
- Requester rules:
  - A requester may drop req without being granted; this has no effect.
  - After gnt, the requester's inputs are don't-care.
  - A requester may issue its next request in the same cycle its rvalid is high; that request can be granted in that RESP cycle.
- Reset: asynchronous, active-low.
  - State -> IDLE, last_grant -> DBG, command register -> 0.
  - All gnt, rvalid, rdata, err and mem_* outputs are 0 while reset is asserted.
  - Reset asserted during ACCESS forces mem_write_o low immediately; the in-flight store is not committed and no rvalid is produced.
- Without the optional feature, err_o is constant 0 and ctrl size 11 is passed through unchanged (memory returns 0).

Optional Feature:
DMEM_ALIGN_CHECK_EN.
- Defined: a captured command is faulty if any of the following holds:
  - size == 11;
  - halfword with addr[0] != 0;
  - word with addr[1:0] != 0;
  - addr[31:ADDR_WIDTH] != 0.
- A faulty command still passes through ACCESS, but mem_read_o and mem_write_o stay 0, so memory is untouched.
- In RESP, rvalid_o pulses with err_o = 1 and rdata_o = 0.
- Undefined: no checks are performed, and err_o is tied to 0.

Decomposition:
- Package dmem_arb_pkg contains:
  - the state_t enum (IDLE, ACCESS, RESP);
  - the req_id_t enum (CPU, DBG);
  - size constants SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10;
  - the packed struct mem_cmd_t {we, addr, wdata, ctrl, id}.
- Sub-module dmem_rr_picker: 2-way picker with inputs req[1:0], last_grant and FIXED_PRIO, output grant one-hot. Purely combinational; last_grant is stored in dmem_arbiter.

Test Plan:
- CPU store, then load: SW 0xDEADBEEF @0x10000 with ctrl 010 -> gnt at T, mem_write_o=1 at T+1, rvalid at T+2. Then LW @0x10000 -> cpu_rdata_o=0xDEADBEEF two cycles after gnt.
- Load extension: memory byte @0x10004 = 0x80. LB (ctrl 000) -> rdata 0xFFFFFF80; LBU (ctrl 100) -> 0x00000080.
- Tie arbitration with FIXED_PRIO=0: both reqs held continuously from reset release -> grant order CPU, DBG, CPU, DBG; gnt every 2 cycles; each rvalid only on the owning port.
- Fixed priority with FIXED_PRIO=1: same stimulus -> CPU granted every time; dbg_gnt_o stays 0 while cpu_req_i is held.
- Reset mid-operation: assert rst_ni low during ACCESS of SW 0x12345678 @0x10010 -> mem_write_o drops immediately, no rvalid. After release, LW @0x10010 returns the old contents.
- DMEM_ALIGN_CHECK_EN defined: LW @0x10002 -> no mem_read_o pulse; rvalid with err_o=1, rdata=0. SH @0x10001 -> memory unchanged, err_o=1.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types for the data-memory arbiter:
//   state_t    - sequencer states (IDLE, ACCESS, RESP)
//   req_id_t   - requester identity (CPU, DBG); also the bit index of each
//                requester in the picker's request/grant vectors
//   SIZE_*     - access-size encodings carried in ctrl[1:0]
//   mem_cmd_t  - registered command {we, addr, wdata, ctrl, id}
//   cmd_is_faulty() - alignment / range check used when the
//                DMEM_ALIGN_CHECK_EN build option is defined
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        CPU = 1'b0,
        DBG = 1'b1
    } req_id_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
        req_id_t     id;
    } mem_cmd_t;

    // A command is faulty when its size is the reserved encoding, when a
    // halfword/word is not naturally aligned, or when any address bit above
    // the memory's byte-address range is set.
    function automatic logic cmd_is_faulty(input mem_cmd_t cmd,
                                           input logic [31:0] addr_mask);
        logic bad_size;
        logic bad_align;
        logic out_of_range;
        bad_size     = (cmd.ctrl[1:0] == 2'b11);
        bad_align    = ((cmd.ctrl[1:0] == SIZE_H) && cmd.addr[0]) ||
                       ((cmd.ctrl[1:0] == SIZE_W) && (cmd.addr[1:0] != 2'b00));
        out_of_range = ((cmd.addr & ~addr_mask) != 32'd0);
        return bad_size || bad_align || out_of_range;
    endfunction

endpackage

// File: rtl/dmem_rr_picker.sv
// -----------------------------------------------------------------------------
// dmem_rr_picker
// Two-way combinational request picker.
//   req[1:0]    in   request vector, bit CPU (0) and bit DBG (1)
//   last_grant  in   requester granted most recently (stored by the caller)
//   grant[1:0]  out  one-hot grant, all zero when nobody requests
// Parameter FIXED_PRIO: 0 = a tie goes to the requester not granted last,
//                       1 = a tie always goes to the CPU.
// A lone requester is always granted regardless of FIXED_PRIO.
// -----------------------------------------------------------------------------
module dmem_rr_picker
    import dmem_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] req,
    input  req_id_t    last_grant,
    output logic [1:0] grant
);

    // NOTE: every signal written in an always_comb gets a default first so
    //       no path through the block can leave it unassigned (no latch).
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            if (FIXED_PRIO || (last_grant == DBG)) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-memory port between the CPU MEM stage and a
// debug/loader port. Each accepted request is registered, presented to memory
// for exactly one cycle (ACCESS) and completed with a one-cycle rvalid pulse
// on the owning port (RESP). A new request may be accepted in RESP, giving
// one access every two cycles under continuous load.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   cpu_req_i/we_i/addr_i/wdata_i/ctrl_i   CPU request
//   cpu_gnt_o                     combinational accept (req & gnt = handshake)
//   cpu_rvalid_o/rdata_o/err_o    registered completion pulse and result
//   dbg_*                         debug port, same meanings as cpu_*
//   mem_read_o/write_o/addr_o/wdata_o/ctrl_o   memory command, ACCESS only
//   mem_rdata_i                   combinational memory read data
//
// Build option DMEM_ALIGN_CHECK_EN: when defined, misaligned, reserved-size
// or out-of-range commands are blocked from memory and complete with err=1,
// rdata=0. When undefined, err outputs are constant 0 and ctrl is passed
// through unchanged.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic [2:0]  cpu_ctrl_i,
    output logic        cpu_gnt_o,
    output logic        cpu_rvalid_o,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_err_o,

    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic [2:0]  dbg_ctrl_i,
    output logic        dbg_gnt_o,
    output logic        dbg_rvalid_o,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_err_o,

    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [2:0]  mem_ctrl_o,
    input  logic [31:0] mem_rdata_i
);

    // Bits above the memory's byte-address range carry no meaning
    // downstream; they are driven as zero on mem_addr_o.
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFF >> (32 - ADDR_WIDTH);

    state_t     state;
    req_id_t    last_grant;
    mem_cmd_t   cmd;
    mem_cmd_t   next_cmd;
    logic [1:0] req_vec;
    logic [1:0] pick;
    logic       can_grant;
    logic       accept;
    logic       cmd_fault;
    logic [31:0] resp_data;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign req_vec = {dbg_req_i, cpu_req_i};

    dmem_rr_picker #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_picker (
        .req        (req_vec),
        .last_grant (last_grant),
        .grant      (pick)
    );

    // Grants are only offered while the memory port is free (IDLE or RESP).
    // Gating with rst_ni keeps them low for the whole reset window even
    // though the state register already reads IDLE.
    assign can_grant = rst_ni && ((state == IDLE) || (state == RESP));
    assign cpu_gnt_o = can_grant && pick[CPU];
    assign dbg_gnt_o = can_grant && pick[DBG];
    assign accept    = cpu_gnt_o || dbg_gnt_o;

    always_comb begin
        next_cmd = '{we: dbg_we_i, addr: dbg_addr_i, wdata: dbg_wdata_i,
                     ctrl: dbg_ctrl_i, id: DBG};
        if (pick[CPU]) begin
            next_cmd = '{we: cpu_we_i, addr: cpu_addr_i, wdata: cpu_wdata_i,
                         ctrl: cpu_ctrl_i, id: CPU};
        end
    end

    // ------------------------------------------------------------------
    // Command checking
    // ------------------------------------------------------------------
`ifdef DMEM_ALIGN_CHECK_EN
    assign cmd_fault = cmd_is_faulty(cmd, ADDR_MASK);
`else
    assign cmd_fault = 1'b0;
`endif

    // Stores and faulty commands complete with zero data.
    always_comb begin
        resp_data = mem_rdata_i;
        if (cmd.we || cmd_fault) begin
            resp_data = '0;
        end
    end

    // ------------------------------------------------------------------
    // Memory drive: only during ACCESS, zero otherwise. Derived from the
    // state register, so an asynchronous reset during ACCESS drops
    // mem_write_o at once and the in-flight store is never committed.
    // ------------------------------------------------------------------
    always_comb begin
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_ctrl_o  = '0;
        if (state == ACCESS) begin
            mem_read_o  = !cmd.we && !cmd_fault;
            mem_write_o =  cmd.we && !cmd_fault;
            mem_addr_o  = cmd.addr & ADDR_MASK;
            mem_wdata_o = cmd.wdata;
            mem_ctrl_o  = cmd.ctrl;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer with registered completion outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only,
    //       so every flop samples the pre-edge values regardless of order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            last_grant   <= DBG;
            // NOTE: the command register is reset as well; it is a handful
            //       of flops, not a RAM, and a known value keeps mem_* clean.
            cmd          <= '0;
            cpu_rvalid_o <= 1'b0;
            cpu_rdata_o  <= '0;
            cpu_err_o    <= 1'b0;
            dbg_rvalid_o <= 1'b0;
            dbg_rdata_o  <= '0;
            dbg_err_o    <= 1'b0;
        end else begin
            cpu_rvalid_o <= 1'b0;
            dbg_rvalid_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    // Read data is sampled at the end of ACCESS and returned
                    // only on the port that owns the command; the other
                    // port's rdata keeps its last response.
                    if (cmd.id == CPU) begin
                        cpu_rvalid_o <= 1'b1;
                        cpu_rdata_o  <= resp_data;
                        cpu_err_o    <= cmd_fault;
                    end else begin
                        dbg_rvalid_o <= 1'b1;
                        dbg_rdata_o  <= resp_data;
                        dbg_err_o    <= cmd_fault;
                    end
                end
                RESP: begin
                    state <= accept ? ACCESS : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (accept) begin
                cmd        <= next_cmd;
                last_grant <= pick[CPU] ? CPU : DBG;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. A byte-addressed memory model sits on
// the mem_* port. A monitor tracks accepted requests in a scoreboard queue
// (acceptance order) and, when a response is due two cycles later, computes
// the expected result from a separate reference memory. A second instance
// with FIXED_PRIO=1 is exercised with both requesters held high.
// Build option DMEM_ALIGN_CHECK_EN enables the fault expectations.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int ADDR_W = 17;
    localparam bit FIXED_PRIO_MAIN = 1'b0;
    localparam logic [31:0] ADDR_MASK = (32'd1 << ADDR_W) - 32'd1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [2:0]  cpu_ctrl = '0;
    logic        cpu_gnt, cpu_rvalid, cpu_err;
    logic [31:0] cpu_rdata;

    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic [2:0]  dbg_ctrl = '0;
    logic        dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] dbg_rdata;

    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_ctrl;

    // fixed-priority instance
    logic        fx_req = 1'b0;
    logic        fx_cpu_gnt, fx_cpu_rvalid, fx_cpu_err;
    logic [31:0] fx_cpu_rdata;
    logic        fx_dbg_gnt, fx_dbg_rvalid, fx_dbg_err;
    logic [31:0] fx_dbg_rdata;
    logic        fx_mem_read, fx_mem_write;
    logic [31:0] fx_mem_addr, fx_mem_wdata;
    logic [2:0]  fx_mem_ctrl;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(ADDR_W), .FIXED_PRIO(FIXED_PRIO_MAIN)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_ctrl_i(cpu_ctrl),
        .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
        .cpu_err_o(cpu_err),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_ctrl_i(dbg_ctrl),
        .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
        .dbg_err_o(dbg_err),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ctrl_o(mem_ctrl), .mem_rdata_i(mem_rdata)
    );

    dmem_arbiter #(.ADDR_WIDTH(ADDR_W), .FIXED_PRIO(1'b1)) u_fix (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_req_i(fx_req), .cpu_we_i(1'b0), .cpu_addr_i(32'h0001_0000),
        .cpu_wdata_i(32'h0), .cpu_ctrl_i(3'b010),
        .cpu_gnt_o(fx_cpu_gnt), .cpu_rvalid_o(fx_cpu_rvalid),
        .cpu_rdata_o(fx_cpu_rdata), .cpu_err_o(fx_cpu_err),
        .dbg_req_i(fx_req), .dbg_we_i(1'b0), .dbg_addr_i(32'h0001_0004),
        .dbg_wdata_i(32'h0), .dbg_ctrl_i(3'b010),
        .dbg_gnt_o(fx_dbg_gnt), .dbg_rvalid_o(fx_dbg_rvalid),
        .dbg_rdata_o(fx_dbg_rdata), .dbg_err_o(fx_dbg_err),
        .mem_read_o(fx_mem_read), .mem_write_o(fx_mem_write),
        .mem_addr_o(fx_mem_addr), .mem_wdata_o(fx_mem_wdata),
        .mem_ctrl_o(fx_mem_ctrl), .mem_rdata_i(32'h0)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // ------------------------------------------------------------------
    // Memories: dut_mem serves the DUT's memory port, ref_mem is the
    // reference the scoreboard predicts from. Both start empty (all zero).
    // ------------------------------------------------------------------
    logic [7:0] dut_mem [int];
    logic [7:0] ref_mem [int];

    function automatic logic [7:0] rd_byte(input bit use_ref, input logic [31:0] a);
        int k;
        k = int'(a & ADDR_MASK);
        if (use_ref) return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
        return dut_mem.exists(k) ? dut_mem[k] : 8'h00;
    endfunction

    function automatic int size_bytes(input logic [2:0] ctrl);
        case (ctrl[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    // Little-endian load with sign or zero extension; reserved size reads 0.
    function automatic logic [31:0] mem_load(input bit use_ref, input logic [31:0] a,
                                             input logic [2:0] ctrl);
        logic [31:0] v;
        int n;
        v = '0;
        n = size_bytes(ctrl);
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd_byte(use_ref, a + i);
        if (n > 0 && n < 4 && !ctrl[2] && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        return v;
    endfunction

    task automatic mem_store(input bit use_ref, input logic [31:0] a,
                             input logic [31:0] wdata, input logic [2:0] ctrl);
        int n;
        int k;
        n = size_bytes(ctrl);
        for (int i = 0; i < n; i++) begin
            k = int'((a + i) & ADDR_MASK);
            if (use_ref) ref_mem[k] = wdata[8*i +: 8];
            else         dut_mem[k] = wdata[8*i +: 8];
        end
    endtask

    always @(mem_read or mem_addr or mem_ctrl) begin
        mem_rdata = mem_read ? mem_load(1'b0, mem_addr, mem_ctrl) : 32'h0;
    end

    always @(posedge clk) begin
        if (mem_write) mem_store(1'b0, mem_addr, mem_wdata, mem_ctrl);
    end

    function automatic bit is_faulty(input logic [31:0] a, input logic [2:0] ctrl);
        bit f;
        f = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        f = (ctrl[1:0] == 2'd3) ||
            (ctrl[1:0] == 2'd1 && (a % 2) != 0) ||
            (ctrl[1:0] == 2'd2 && (a % 4) != 0) ||
            (a >= (32'd1 << ADDR_W));
`endif
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
        bit          id;     // 1 = debug port
        int          cyc;
    } txn_t;

    txn_t sb_q[$];
    txn_t last_acc;
    bit   prev_hs = 1'b0;
    bit   last_dbg = 1'b1;
    bit   cpu_hs_prev = 1'b0;
    bit   dbg_hs_prev = 1'b0;
    int   cyc = 0;

    always @(negedge clk) begin : monitor
        txn_t        t;
        bit          f;
        bit          win_dbg;
        logic [1:0]  exp_rv;
        logic [1:0]  exp_gnt;
        logic [95:0] exp_mem;
        logic [31:0] exp_data;
        cyc++;
        cpu_hs_prev = 1'b0;
        dbg_hs_prev = 1'b0;
        if (!rst_n) begin
            sb_q.delete();
            prev_hs  = 1'b0;
            last_dbg = 1'b1;
        end else begin
            // memory port: busy only in the cycle after an acceptance
            exp_mem = '0;
            if (prev_hs) begin
                f = is_faulty(last_acc.addr, last_acc.ctrl);
                exp_mem = {27'd0, !last_acc.we && !f, last_acc.we && !f,
                           last_acc.addr & ADDR_MASK, last_acc.wdata, last_acc.ctrl};
            end
            check("mem_drive", {27'd0, mem_read, mem_write, mem_addr, mem_wdata, mem_ctrl}, exp_mem);

            // completion: exactly two cycles after acceptance, owner port only
            exp_rv = 2'b00;
            if (sb_q.size() > 0 && sb_q[0].cyc + 2 == cyc) exp_rv = sb_q[0].id ? 2'b10 : 2'b01;
            check("rvalid", {94'd0, dbg_rvalid, cpu_rvalid}, {94'd0, exp_rv});
            if (exp_rv != 2'b00) begin
                t = sb_q.pop_front();
                f = is_faulty(t.addr, t.ctrl);
                exp_data = (t.we || f) ? 32'h0 : mem_load(1'b1, t.addr, t.ctrl);
                if (t.we && !f) mem_store(1'b1, t.addr, t.wdata, t.ctrl);
                if (t.id) check("dbg_resp", {63'd0, dbg_err, dbg_rdata}, {63'd0, f, exp_data});
                else      check("cpu_resp", {63'd0, cpu_err, cpu_rdata}, {63'd0, f, exp_data});
            end

            // grant: port is free unless something was accepted last cycle
            exp_gnt = 2'b00;
            if (!prev_hs && (cpu_req || dbg_req)) begin
                if (cpu_req && dbg_req) win_dbg = FIXED_PRIO_MAIN ? 1'b0 : !last_dbg;
                else                    win_dbg = dbg_req;
                exp_gnt = win_dbg ? 2'b10 : 2'b01;
            end
            check("gnt", {94'd0, dbg_gnt, cpu_gnt}, {94'd0, exp_gnt});
            prev_hs = (exp_gnt != 2'b00);
            if (exp_gnt == 2'b01) begin
                last_acc = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, ctrl: cpu_ctrl, id: 1'b0, cyc: cyc};
                sb_q.push_back(last_acc);
                last_dbg = 1'b0;
                cpu_hs_prev = 1'b1;
            end else if (exp_gnt == 2'b10) begin
                last_acc = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata, ctrl: dbg_ctrl, id: 1'b1, cyc: cyc};
                sb_q.push_back(last_acc);
                last_dbg = 1'b1;
                dbg_hs_prev = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_port(input bit port, input bit req, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] ctrl);
        if (port) begin
            dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_ctrl = ctrl;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_ctrl = ctrl;
        end
    endtask

    // One request on one port; returns #1 after the response cycle has ended.
    task automatic issue(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] ctrl);
        int n;
        bit got;
        @(posedge clk); #1;
        set_port(port, 1'b1, we, addr, wdata, ctrl);
        got = 1'b0;
        n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = port ? dbg_gnt : cpu_gnt;
        end
        check("gnt_wait", {95'd0, got}, 96'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic rand_port(input bit port);
        bit          req_now;
        bit          hs;
        logic [31:0] a;
        logic [2:0]  c;
        req_now = port ? dbg_req : cpu_req;
        hs      = port ? dbg_hs_prev : cpu_hs_prev;
        if (!req_now || hs) begin
            if ($urandom_range(0, 3) != 0) begin
                a = 32'h0001_0000 + $urandom_range(0, 31);
                if ($urandom_range(0, 15) == 0) a = a | 32'h0010_0000;
                c[1:0] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                c[2]   = 1'($urandom_range(0, 1));
                set_port(port, 1'b1, 1'($urandom_range(0, 1)), a, $urandom, c);
            end else begin
                set_port(port, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
            end
        end else if ($urandom_range(0, 15) == 0) begin
            // withdraw without having been granted
            set_port(port, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : main
        int          n_gnt;
        logic [3:0]  order;
        logic [31:0] gnt_at;
        int          fx_cpu_g, fx_dbg_g, fx_cpu_rv, fx_dbg_rv, fx_wr;

        // Outputs are quiet during reset even with requests pending.
        cpu_req = 1'b1;
        dbg_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {54'd0, cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_err, dbg_err, mem_read, mem_write, mem_addr},
              96'd0);
        check("reset_data", {32'd0, cpu_rdata, dbg_rdata}, 96'd0);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        rst_n = 1'b1;

        // CPU store then load of the same word.
        issue(1'b0, 1'b1, 32'h0001_0000, 32'hDEAD_BEEF, 3'b010);
        issue(1'b0, 1'b0, 32'h0001_0000, 32'h0, 3'b010);
        check("lw_deadbeef", {64'd0, cpu_rdata}, {64'd0, 32'hDEAD_BEEF});

        // Byte 0x80 written via debug, then signed and unsigned byte loads.
        issue(1'b1, 1'b1, 32'h0001_0004, 32'h0000_0080, 3'b000);
        issue(1'b0, 1'b0, 32'h0001_0004, 32'h0, 3'b000);
        check("lb_sext", {64'd0, cpu_rdata}, {64'd0, 32'hFFFF_FF80});
        issue(1'b0, 1'b0, 32'h0001_0004, 32'h0, 3'b100);
        check("lbu_zext", {64'd0, cpu_rdata}, {64'd0, 32'h0000_0080});

        // Reset during the ACCESS cycle of a store.
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b1, 32'h0001_0010, 32'h1234_5678, 3'b010);
        @(negedge clk);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        #1;
        check("abort_write_before", {95'd0, mem_write}, 96'd1);
        rst_n = 1'b0;
        #1;
        check("abort_write_drop", {94'd0, mem_write, cpu_rvalid}, 96'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        issue(1'b0, 1'b0, 32'h0001_0010, 32'h0, 3'b010);
        check("abort_old_data", {64'd0, cpu_rdata}, 96'd0);

        // Both requesters held from reset release.
        rst_n = 1'b0;
        set_port(1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 3'b010);
        set_port(1'b1, 1'b1, 1'b0, 32'h0001_0004, 32'h0, 3'b010);
        fx_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_gnt = 0; order = '0; gnt_at = '0;
        fx_cpu_g = 0; fx_dbg_g = 0; fx_cpu_rv = 0; fx_dbg_rv = 0; fx_wr = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cpu_gnt || dbg_gnt) begin
                if (n_gnt < 4) begin
                    order[n_gnt]       = dbg_gnt;
                    gnt_at[8*n_gnt +: 8] = 8'(i);
                end
                n_gnt++;
            end
            fx_cpu_g  += int'(fx_cpu_gnt);
            fx_dbg_g  += int'(fx_dbg_gnt);
            fx_cpu_rv += int'(fx_cpu_rvalid);
            fx_dbg_rv += int'(fx_dbg_rvalid);
            fx_wr     += int'(fx_mem_write);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        fx_req  = 1'b0;
        check("rr_count", 96'(n_gnt), 96'd4);
        check("rr_order", {92'd0, order}, {92'd0, 4'b1010});
        check("rr_spacing", {64'd0, gnt_at}, {64'd0, 32'h0604_0200});
        check("fixed_cpu_gnts", 96'(fx_cpu_g), 96'd4);
        check("fixed_dbg_quiet", {32'(fx_dbg_g), 32'(fx_dbg_rv), 32'(fx_wr)}, 96'd0);
        check("fixed_cpu_rvalids", 96'(fx_cpu_rv), 96'd3);
        repeat (4) @(posedge clk);

`ifdef DMEM_ALIGN_CHECK_EN
        issue(1'b0, 1'b0, 32'h0001_0002, 32'h0, 3'b010);
        check("lw_misaligned", {63'd0, cpu_err, cpu_rdata}, {63'd0, 1'b1, 32'h0});
        issue(1'b1, 1'b1, 32'h0001_0001, 32'h0000_BEEF, 3'b001);
        check("sh_misaligned", {63'd0, dbg_err, dbg_rdata}, {63'd0, 1'b1, 32'h0});
        issue(1'b0, 1'b0, 32'h0001_0000, 32'h0, 3'b010);
        check("mem_untouched", {63'd0, cpu_err, cpu_rdata}, {63'd0, 1'b0, 32'hDEAD_BEEF});
`else
        issue(1'b0, 1'b0, 32'h0001_0000, 32'h0, 3'b011);
        check("size11_passthru", {63'd0, cpu_err, cpu_rdata}, 96'd0);
        issue(1'b1, 1'b0, 32'h0001_0002, 32'h0, 3'b001);
        check("lh_unaligned_ok", {63'd0, dbg_err, dbg_rdata}, {63'd0, 1'b0, 32'hFFFF_DEAD});
`endif

        // Randomized traffic on both ports.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            rand_port(1'b0);
            rand_port(1'b1);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        repeat (6) @(posedge clk);
        check("scoreboard_drained", 96'(sb_q.size()), 96'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
